// File: rtl/mips_pkg.sv
// Shared MEM-stage definitions: access-size codes, load/store FSM states and
// the helper that sizes the bus timeout counter.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ls_state_e;

    // A zero timeout still needs a 1-bit counter to keep the declaration legal.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// Data-memory request/ack bus between the MEM stage (master) and the memory
// or bus fabric (slave).
interface mem_stage_ls_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [31:0]           dmem_wdata;
    logic [31:0]           dmem_rdata;
    logic                  dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for sized loads/stores: byte enables, replicated write
// data, misalignment detection and sign/zero-extended load data.
module load_store_align
    import mips_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Size code 2'b11 falls into the default (word) arm everywhere.
    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = (addr_lo != 2'b00);
        load_data  = rdata;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata      = {4{store_data[7:0]}};
                misaligned = 1'b0;
                load_data  = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
                load_data  = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_ls.sv
// MIPS MEM stage: issues sized loads/stores on a req/ack data bus, stalls the
// pipeline while waiting, bounds the wait with a bus-error timeout, and
// registers the result into the MEM/WB pipeline register.
module mem_stage_ls
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [ADDR_WIDTH-1:0]     alu_result,
    input  logic [31:0]               store_data,
    input  logic [REG_ADDR_WIDTH-1:0] reg_dest,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_size,
    input  logic                      mem_unsigned,
    input  logic                      reg_write,
    input  logic                      mem_to_reg,
    output logic                      stall,
    mem_stage_ls_if.master            dmem,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic                      wb_mem_to_reg,
    output logic [31:0]               wb_read_data,
    output logic [ADDR_WIDTH-1:0]     wb_alu_result,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_dest,
    output logic                      misalign_exc,
    output logic                      bus_err
);

    localparam int            CW      = cnt_width(TIMEOUT_CYCLES);
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    ls_state_e     state;
    logic [CW-1:0] cnt;

    logic        mem_op;
    logic        misaligned;
    logic        aligned;
    logic        timeout;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;

    load_store_align u_align (
        .addr_lo     (alu_result[1:0]),
        .size        (mem_size),
        .is_unsigned (mem_unsigned),
        .store_data  (store_data),
        .rdata       (dmem.dmem_rdata),
        .be          (be),
        .wdata       (wdata),
        .misaligned  (misaligned),
        .load_data   (load_data)
    );

    assign mem_op  = in_valid & (mem_read | mem_write);
    assign aligned = mem_op & ~misaligned;

    // The issuing IDLE cycle is counted, so the counter enters WAIT at 1 and
    // the request stays up for exactly TIMEOUT_CYCLES cycles before giving up.
    assign timeout = TO_EN && (state == ST_WAIT) && !dmem.dmem_ack && (cnt >= TO_LAST);

    assign stall = rst_n & aligned & ~dmem.dmem_ack & ~timeout;

    assign dmem.dmem_req   = rst_n & aligned;
    assign dmem.dmem_we    = mem_write;
    assign dmem.dmem_addr  = {alu_result[ADDR_WIDTH-1:2], 2'b00};
    assign dmem.dmem_be    = be;
    assign dmem.dmem_wdata = wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aligned && !dmem.dmem_ack) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (dmem.dmem_ack || timeout) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_reg_dest   <= '0;
            misalign_exc  <= 1'b0;
            bus_err       <= 1'b0;
        end else if (stall) begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid      <= in_valid;
            wb_reg_write  <= in_valid & reg_write & ~(mem_op & misaligned) & ~timeout;
            wb_mem_to_reg <= mem_to_reg;
            wb_read_data  <= load_data;
            wb_alu_result <= alu_result;
            wb_reg_dest   <= reg_dest;
            misalign_exc  <= mem_op & misaligned;
            bus_err       <= timeout;
        end
    end

endmodule
